// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations in a DEPTH-entry shadow pipeline, produces registered EX forward
// selects and a combinational load-use stall. Define FWD_HAZARD_PERF_EN to add perf counters.
module fwd_hazard_unit #(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned DEPTH          = 3,
  parameter int unsigned LOAD_FWD_STAGE = 3,
  parameter int unsigned REG_W          = $clog2(NUM_REGS),
  parameter int unsigned SRC_W          = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_we_i,
  input  logic             id_load_i,
  output logic             stall_o,
  output logic [SRC_W-1:0] sel_rs1_src_o,
  output logic [SRC_W-1:0] sel_rs2_src_o
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      fwd_cnt_o
`endif
);

  typedef struct packed {
    logic             valid;
    logic             we;
    logic             load;
    logic [REG_W-1:0] rd;
  } entry_t;

  // Entry 1 is EX, entry DEPTH is the last stage before the regfile write.
  entry_t ent_q [1:DEPTH];
  entry_t ent_d [1:DEPTH];

  logic [SRC_W-1:0] sel1_q, sel1_d;
  logic [SRC_W-1:0] sel2_q, sel2_d;
  logic [SRC_W-1:0] fwd1, fwd2;
  logic             hz1, hz2;
  logic             issue;

  // Descending scan so the youngest (smallest k) match overwrites older ones. Entry DEPTH is
  // skipped: the write-first regfile already exposes that producer.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    hz1  = 1'b0;
    hz2  = 1'b0;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (ent_q[k].valid && ent_q[k].we && (id_rs1_i != '0) && (ent_q[k].rd == id_rs1_i)) begin
        fwd1 = SRC_W'(k);
        hz1  = ent_q[k].load && ((k + 1) < LOAD_FWD_STAGE);
      end
      if (ent_q[k].valid && ent_q[k].we && (id_rs2_i != '0) && (ent_q[k].rd == id_rs2_i)) begin
        fwd2 = SRC_W'(k);
        hz2  = ent_q[k].load && ((k + 1) < LOAD_FWD_STAGE);
      end
    end
  end

  assign stall_o = id_valid_i && !flush_i && (hz1 || hz2);
  assign issue   = id_valid_i && !flush_i && !stall_o;

  always_comb begin
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      ent_d[k] = ent_q[k-1];
    end
    ent_d[1].valid = issue;
    ent_d[1].we    = id_we_i;
    ent_d[1].load  = id_load_i;
    ent_d[1].rd    = id_rd_i;
    sel1_d         = issue ? fwd1 : '0;
    sel2_d         = issue ? fwd2 : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      sel1_q <= '0;
      sel2_q <= '0;
    end else if (advance_i) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
    end
  end

  assign sel_rs1_src_o = sel1_q;
  assign sel_rs2_src_o = sel2_q;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_o && advance_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (advance_i && ((sel1_d != '0) || (sel2_d != '0)) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed literal checks plus random traffic against an
// instruction-history model.
module tb_fwd_hazard_unit;

  localparam int NUM_REGS = 32;
  localparam int DEPTH    = 3;
  localparam int LFS      = 3;
  localparam int REG_W    = 5;
  localparam int SRC_W    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, advance_i, flush_i, id_valid_i, id_we_i, id_load_i;
  logic [REG_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic             stall_o;
  logic [SRC_W-1:0] sel_rs1_src_o, sel_rs2_src_o;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]      stall_cnt_o, fwd_cnt_o;
`endif

  fwd_hazard_unit #(
    .NUM_REGS      (NUM_REGS),
    .DEPTH         (DEPTH),
    .LOAD_FWD_STAGE(LFS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .advance_i    (advance_i),
    .flush_i      (flush_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_we_i      (id_we_i),
    .id_load_i    (id_load_i),
    .stall_o      (stall_o),
    .sel_rs1_src_o(sel_rs1_src_o),
    .sel_rs2_src_o(sel_rs2_src_o)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .fwd_cnt_o    (fwd_cnt_o)
`endif
  );

  // hist[a-1] is the instruction (or bubble) that entered EX a advances ago.
  typedef struct {
    bit valid;
    bit we;
    bit ld;
    int rd;
  } rec_t;

  rec_t   hist[$];
  rec_t   m_rec;
  int     m_sel1, m_sel2;
  longint m_scnt, m_fcnt;
  bit     m_st, m_go;
  bit     chk_en = 1'b0;
  int     n_checks = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Age of the youngest producer of rs among the forwardable ages, 0 when none.
  function automatic int pick(input int rs);
    if (rs == 0) return 0;
    for (int a = 1; a <= DEPTH - 1; a++) begin
      if (a <= hist.size() && hist[a-1].valid && hist[a-1].we && hist[a-1].rd == rs) return a;
    end
    return 0;
  endfunction

  function automatic bit model_stall();
    int a;
    if (!id_valid_i || flush_i) return 1'b0;
    a = pick(int'(id_rs1_i));
    if (a != 0 && hist[a-1].ld && a + 1 < LFS) return 1'b1;
    a = pick(int'(id_rs2_i));
    if (a != 0 && hist[a-1].ld && a + 1 < LFS) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      hist.delete();
      m_sel1 = 0;
      m_sel2 = 0;
      m_scnt = 0;
      m_fcnt = 0;
      chk_en = 1'b1;
    end else if (advance_i) begin
      m_st = model_stall();
      m_go = id_valid_i && !flush_i && !m_st;
      if (m_st && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      m_sel1 = m_go ? pick(int'(id_rs1_i)) : 0;
      m_sel2 = m_go ? pick(int'(id_rs2_i)) : 0;
      if ((m_sel1 != 0 || m_sel2 != 0) && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      m_rec.valid = m_go;
      m_rec.we    = id_we_i;
      m_rec.ld    = id_load_i;
      m_rec.rd    = int'(id_rd_i);
      hist.push_front(m_rec);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("model_stall", 32'(stall_o), 32'(model_stall()));
      check("model_sel1", 32'(sel_rs1_src_o), 32'(m_sel1));
      check("model_sel2", 32'(sel_rs2_src_o), 32'(m_sel2));
`ifdef FWD_HAZARD_PERF_EN
      check("model_stall_cnt", stall_cnt_o, 32'(m_scnt));
      check("model_fwd_cnt", fwd_cnt_o, 32'(m_fcnt));
`endif
    end
  end

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit we,
                       input bit ld, input bit adv = 1'b1, input bit fl = 1'b0,
                       input bit rs = 1'b0);
    @(negedge clk);
    id_valid_i = v;
    id_rs1_i   = REG_W'(rs1);
    id_rs2_i   = REG_W'(rs2);
    id_rd_i    = REG_W'(rd);
    id_we_i    = we;
    id_load_i  = ld;
    advance_i  = adv;
    flush_i    = fl;
    rst_i      = rs;
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    drive(1'b1, rs1, rs2, rd, 1'b1, 1'b0);
  endtask

  task automatic lw(input int rd, input int rs1);
    drive(1'b1, rs1, 0, rd, 1'b1, 1'b1);
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; advance_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0;
    id_we_i = 1'b0; id_load_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nop(); #1;
    check("reset_stall", 32'(stall_o), 0);
    check("reset_sel1", 32'(sel_rs1_src_o), 0);
    check("reset_sel2", 32'(sel_rs2_src_o), 0);

    // Back-to-back ALU dependency forwards from MEM on both operands.
    alu(5, 0, 0);
    alu(6, 5, 5); #1;
    check("alu_chain_stall", 32'(stall_o), 0);
    nop(); #1;
    check("alu_chain_sel1", 32'(sel_rs1_src_o), 1);
    check("alu_chain_sel2", 32'(sel_rs2_src_o), 1);

    alu(5, 0, 0);
    alu(10, 1, 2);
    alu(11, 5, 0);
    nop(); #1;
    check("dist2_sel1", 32'(sel_rs1_src_o), 2);

    alu(12, 0, 0);
    alu(13, 0, 0);
    alu(14, 0, 0);
    alu(15, 12, 0);
    nop(); #1;
    check("dist3_sel1", 32'(sel_rs1_src_o), 0);

    lw(7, 0);
    alu(8, 7, 0); #1;
    check("loaduse_stall", 32'(stall_o), 1);
    alu(8, 7, 0); #1;
    check("loaduse_release", 32'(stall_o), 0);
    check("loaduse_bubble_sel", 32'(sel_rs1_src_o), 0);
    nop(); #1;
    check("loaduse_sel1", 32'(sel_rs1_src_o), 2);

    alu(9, 0, 0);
    alu(9, 0, 0);
    alu(16, 9, 9);
    nop(); #1;
    check("youngest_sel1", 32'(sel_rs1_src_o), 1);
    check("youngest_sel2", 32'(sel_rs2_src_o), 1);

    drive(1'b1, 0, 0, 0, 1'b1, 1'b1);
    alu(17, 0, 0); #1;
    check("x0_stall", 32'(stall_o), 0);
    nop(); #1;
    check("x0_sel1", 32'(sel_rs1_src_o), 0);
    check("x0_sel2", 32'(sel_rs2_src_o), 0);

    // Freeze while a load-use stall is pending: everything holds.
    alu(20, 0, 0);
    lw(22, 20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 22, 0, 23, 1'b1, 1'b0, 1'b0); #1;
      check("freeze_stall", 32'(stall_o), 1);
      check("freeze_sel1", 32'(sel_rs1_src_o), 1);
    end
    alu(23, 22, 0); #1;
    check("unfreeze_stall", 32'(stall_o), 1);
    check("unfreeze_sel1", 32'(sel_rs1_src_o), 1);
    alu(23, 22, 0); #1;
    check("unfreeze_release", 32'(stall_o), 0);
    check("unfreeze_bubble", 32'(sel_rs1_src_o), 0);
    nop(); #1;
    check("unfreeze_sel1_wb", 32'(sel_rs1_src_o), 2);

    // Flush coincident with a load-use stall: flush wins, nothing enters EX.
    lw(23, 0);
    drive(1'b1, 23, 23, 24, 1'b1, 1'b0, 1'b1, 1'b1); #1;
    check("flush_stall", 32'(stall_o), 0);
    alu(26, 24, 23); #1;
    check("flush_sel1", 32'(sel_rs1_src_o), 0);
    check("flush_sel2", 32'(sel_rs2_src_o), 0);
    check("flush_next_stall", 32'(stall_o), 0);
    nop(); #1;
    check("flushed_untracked", 32'(sel_rs1_src_o), 0);
    check("flush_load_wb", 32'(sel_rs2_src_o), 2);

    // Reset with three live entries, the youngest a load.
    alu(24, 0, 0);
    alu(25, 0, 0);
    lw(26, 0);
    drive(1'b1, 26, 25, 27, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    alu(28, 26, 25); #1;
    check("rst_mid_stall", 32'(stall_o), 0);
    check("rst_mid_sel1", 32'(sel_rs1_src_o), 0);
    check("rst_mid_sel2", 32'(sel_rs2_src_o), 0);
`ifdef FWD_HAZARD_PERF_EN
    check("rst_mid_stall_cnt", stall_cnt_o, 0);
    check("rst_mid_fwd_cnt", fwd_cnt_o, 0);
`endif
    nop(); #1;
    check("rst_mid_sel1_after", 32'(sel_rs1_src_o), 0);
    check("rst_mid_sel2_after", 32'(sel_rs2_src_o), 0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7), $urandom_range(7),
            $urandom_range(99) < 80, $urandom_range(99) < 30, $urandom_range(99) < 85,
            $urandom_range(99) < 8, $urandom_range(199) == 0);
    end

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
